// File: rtl/game_ctrl_fsm_pkg.sv
// game_ctrl_fsm_pkg: shared state encoding, direction indices and default parameters.
package game_ctrl_fsm_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_MOVE  = 3'd2,
    S_SPAWN = 3'd3,
    S_CHECK = 3'd4,
    S_WON   = 3'd5,
    S_LOST  = 3'd6
  } state_t;
  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;
  localparam int DEF_NUM_DIRS   = 4;
  localparam int DEF_DEBOUNCE   = 16;
  localparam int DEF_INIT_TILES = 2;
  localparam int DEF_TIMEOUT    = 255;
  localparam int DEF_COUNT_W    = 16;
  localparam int DEF_CONTINUE   = 1;
endpackage

// File: rtl/game_ctrl_fsm_btn_conditioner.sv
// game_ctrl_fsm_btn_conditioner: sync, debounce and rising-edge detect raw buttons; lowest index wins.
module game_ctrl_fsm_btn_conditioner
  import game_ctrl_fsm_pkg::*;
#(
  parameter int NUM_DIRS        = DEF_NUM_DIRS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_DIRS-1:0]         buttons_i,
  output logic                        ev_o,
  output logic [$clog2(NUM_DIRS)-1:0] ev_idx_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DW = $clog2(NUM_DIRS);
  logic [NUM_DIRS-1:0] s1_q, s2_q, lvl_q, rise_q;
  logic [CW-1:0] cnt_q [NUM_DIRS];
  // cnt_q counts consecutive cycles the synced input disagrees with the accepted level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= '0;
      s2_q   <= '0;
      lvl_q  <= '0;
      rise_q <= '0;
      for (int i = 0; i < NUM_DIRS; i++) cnt_q[i] <= '0;
    end else begin
      s1_q <= buttons_i;
      s2_q <= s1_q;
      for (int i = 0; i < NUM_DIRS; i++) begin
        rise_q[i] <= 1'b0;
        if (s2_q[i] == lvl_q[i]) cnt_q[i] <= '0;
        else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt_q[i]  <= '0;
          lvl_q[i]  <= s2_q[i];
          rise_q[i] <= s2_q[i];
        end else cnt_q[i] <= cnt_q[i] + CW'(1);
      end
    end
  end
  always_comb begin
    ev_o     = |rise_q;
    ev_idx_o = '0;
    for (int i = NUM_DIRS - 1; i >= 0; i--) if (rise_q[i]) ev_idx_o = DW'(i);
  end
endmodule

// File: rtl/game_ctrl_fsm.sv
// game_ctrl_fsm: 2048 control FSM sequencing button moves, tile spawns, win/loss and timeouts.
module game_ctrl_fsm
  import game_ctrl_fsm_pkg::*;
#(
  parameter int NUM_DIRS           = DEF_NUM_DIRS,
  parameter int DEBOUNCE_CYCLES    = DEF_DEBOUNCE,
  parameter int INIT_TILES         = DEF_INIT_TILES,
  parameter int TIMEOUT_CYCLES     = DEF_TIMEOUT,
  parameter int COUNT_W            = DEF_COUNT_W,
  parameter int CONTINUE_AFTER_WIN = DEF_CONTINUE
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_DIRS-1:0]         buttons_i,
  input  logic                        restart_i,
  input  logic                        move_done_i,
  input  logic                        moved_i,
  input  logic                        spawn_done_i,
  input  logic                        won_i,
  input  logic                        lost_i,
  output logic [2:0]                  state_o,
  output logic                        move_req_o,
  output logic [$clog2(NUM_DIRS)-1:0] move_dir_o,
  output logic                        spawn_req_o,
  output logic                        game_won_o,
  output logic                        game_lost_o,
  output logic [COUNT_W-1:0]          move_count_o,
  output logic                        timeout_err_o
);
  localparam int DW = $clog2(NUM_DIRS);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
  localparam int LW = $clog2(INIT_TILES + 1);
  state_t state_q, state_d;
  logic [DW-1:0] dir_q, dir_d, ev_idx;
  logic [LW-1:0] left_q, left_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic win_q, win_d, gap_q, gap_d, terr_q, terr_d, ev, tmo_fire;
  game_ctrl_fsm_btn_conditioner #(
    .NUM_DIRS       (NUM_DIRS),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .buttons_i(buttons_i),
    .ev_o     (ev),
    .ev_idx_o (ev_idx)
  );
  assign tmo_fire = (TIMEOUT_CYCLES != 0) && (tmo_q == TW'(TIMEOUT_CYCLES));
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      dir_q   <= '0;
      left_q  <= '0;
      tmo_q   <= '0;
      cnt_q   <= '0;
      win_q   <= 1'b0;
      gap_q   <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      left_q  <= left_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      gap_q   <= gap_d;
      terr_q  <= terr_d;
    end
  end
  // gap_q marks the single idle cycle between consecutive spawn requests
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    left_d  = left_q;
    tmo_d   = tmo_q + TW'(1);
    cnt_d   = cnt_q;
    win_d   = win_q;
    gap_d   = 1'b0;
    terr_d  = 1'b0;
    case (state_q)
      S_IDLE: if (ev) begin
        state_d = S_SPAWN;
        left_d  = LW'(INIT_TILES);
        tmo_d   = '0;
      end
      S_WAIT: if (ev) begin
        state_d = S_MOVE;
        dir_d   = ev_idx;
        tmo_d   = '0;
      end
      S_MOVE: if (move_done_i) begin
        state_d = moved_i ? S_SPAWN : S_WAIT;
        if (moved_i) begin
          left_d = LW'(1);
          tmo_d  = '0;
          cnt_d  = (&cnt_q) ? cnt_q : cnt_q + COUNT_W'(1);
        end
      end else if (tmo_fire) begin
        state_d = S_WAIT;
        terr_d  = 1'b1;
      end
      S_SPAWN: if (spawn_done_i && !gap_q) begin
        left_d  = left_q - LW'(1);
        state_d = (left_q == LW'(1)) ? S_CHECK : S_SPAWN;
        gap_d   = left_q != LW'(1);
      end else if (tmo_fire) begin
        state_d = S_CHECK;
        terr_d  = 1'b1;
      end
      S_CHECK: begin
        state_d = (won_i && !win_q) ? S_WON : lost_i ? S_LOST : S_WAIT;
        win_d   = win_q | won_i;
      end
      S_WON:   if (CONTINUE_AFTER_WIN != 0 && ev) state_d = S_WAIT;
      S_LOST:  state_d = S_LOST;
      default: state_d = S_IDLE;
    endcase
    if (restart_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      win_d   = 1'b0;
      gap_d   = 1'b0;
      terr_d  = 1'b0;
    end
  end
  assign state_o       = state_q;
  assign move_req_o    = state_q == S_MOVE;
  assign move_dir_o    = dir_q;
  assign spawn_req_o   = state_q == S_SPAWN && !gap_q;
  assign game_won_o    = state_q == S_WON;
  assign game_lost_o   = state_q == S_LOST;
  assign move_count_o  = cnt_q;
  assign timeout_err_o = terr_q;
endmodule
